pkt_tx_serializer: RTL and testbench
====================================

Name: pkt_tx_serializer

Overview:
- Consumes the packet produced by the response stage: a 256-bit packet word, a 4-bit last-byte index and a ready level.
- Serializes the packet byte-by-byte, LSB byte first, into the byte-wide UART transmitter using a start/busy handshake.
- Sits between the response stage and the UART tx; frees the response stage from any knowledge of tx timing.

Parameters:
- DATA_W, 256, width of the packet word; must be a multiple of 8.
- CNT_W, 4, width of the last-byte index; maximum packet length is 2^CNT_W bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_d  in  DATA_W  packet word; byte k is in_d[8k+7:8k].
- in_bytecount  in  CNT_W  index of the last byte to send; 0 means 1 byte.
- in_rdy  in  1  level-held packet-valid from the upstream stage.
- tx_d  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle request to the UART transmitter.
- tx_busy  in  1  UART transmitter busy.
- busy  out  1  high while a packet is being serialized.
- pkt_done  out  1  one-cycle pulse after the last byte completes.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; tx_d=0, tx_start=0, busy=0, pkt_done=0.
- Reset also clears the capture register, byte index and in_rdy edge register (prev_rdy=0). Any packet in flight is dropped.
- Trigger: a rising edge of in_rdy, meaning in_rdy=1 and prev_rdy=0, where prev_rdy is registered every cycle. A level held high sends the packet exactly once.
- Rising edges seen while not in IDLE are ignored and not queued.
- Capture: on a trigger in IDLE, latch in_d and in_bytecount into internal registers, set idx=0, busy=1 and go to SEND. Upstream changes after capture have no effect.
- SEND:
  - If tx_busy=0: drive tx_d = captured byte idx, pulse tx_start for 1 cycle, go to WAIT_ACK.
  - If tx_busy=1: stay in SEND.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. tx_d holds its value.
- WAIT_DONE: wait for tx_busy=0.
  - If idx == last: go to DONE.
  - Otherwise: idx <= idx+1 and go to SEND.
- DONE: pkt_done=1 for 1 cycle, busy=0, go to IDLE.
- A trigger arriving in the same cycle as DONE is ignored. The upstream stage must drop and re-raise in_rdy to send again.
- Latency: tx_start asserts 2 cycles after the rising edge of in_rdy (capture cycle, then SEND) when tx_busy=0.
- Minimum spacing between tx_start pulses is 3 cycles plus the tx busy time.
- Width rules:
  - idx is CNT_W bits; idx never wraps because the walk terminates at last.
  - A last value of 2^CNT_W-1 sends 16 bytes, i.e. captured bits [127:0].
  - Bits above 8*2^CNT_W are ignored.
- tx_start is never asserted while tx_busy=1.
- tx_d is stable from the tx_start cycle until tx_busy falls.

Test Plan:
- Single byte: in_d=8'hfe, in_bytecount=0, in_rdy held high for 20 cycles, tx model busy for 5 cycles per byte -> exactly one tx_start with tx_d=8'hfe; pkt_done pulses once; busy=0 afterwards.
- Multi-byte: in_d[23:0]=24'h33_22_11, in_bytecount=2 -> tx_d sequence 8'h11, 8'h22, 8'h33; 3 tx_start pulses; pkt_done after the third byte falls.
- Re-trigger: raise in_rdy, drop it, raise again after pkt_done -> two complete packets. Also raise in_rdy a second time while busy=1 -> no extra bytes are sent.
- Tx backpressure: hold tx_busy=1 for 10 cycles before the first byte -> tx_start is withheld until tx_busy falls, then asserts within 1 cycle.
- Full length: in_bytecount=15 with byte k=k -> 16 bytes 0x00..0x0F in order; bits [255:128] are never transmitted.
- Reset mid-packet: assert rst_n low during byte 2 of a 4-byte packet -> all outputs 0 immediately. After release with in_rdy still high, no transmission occurs until in_rdy drops and rises again.

Source files
------------

// File: rtl/pkt_tx_serializer_if.sv
// Packet-in / byte-out bundle between the response stage, the serializer and the UART tx.
// The slave modport is the serializer's view; master is the surrounding environment.
interface pkt_tx_serializer_if #(
   parameter int DATA_W = 256,
   parameter int CNT_W  = 4
);
   logic [DATA_W-1:0] in_d;
   logic [CNT_W-1:0]  in_bytecount;
   logic              in_rdy;
   logic [7:0]        tx_d;
   logic              tx_start;
   logic              tx_busy;
   logic              busy;
   logic              pkt_done;

   modport master (
      output in_d, in_bytecount, in_rdy, tx_busy,
      input  tx_d, tx_start, busy, pkt_done
   );

   modport slave (
      input  in_d, in_bytecount, in_rdy, tx_busy,
      output tx_d, tx_start, busy, pkt_done
   );
endinterface

// File: rtl/pkt_tx_serializer.sv
// Captures one packet on an in_rdy rising edge and walks it LSB byte first
// into a byte-wide UART tx using a start/busy handshake.
module pkt_tx_serializer #(
   parameter int DATA_W = 256,
   parameter int CNT_W  = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   pkt_tx_serializer_if.slave   bus
);
   localparam int NBYTES = 1 << CNT_W;

   typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, DONE} state_t;

   state_t                   state, state_n;
   logic [NBYTES-1:0][7:0]   in_bytes, cap;
   logic [CNT_W-1:0]         last, idx;
   logic [7:0]               tx_d_q;
   logic                     tx_start_q;
   logic                     prev_rdy, armed;
   logic                     trig, load, adv, start_n;

   // Only the first NBYTES bytes are reachable; anything above is dropped.
   for (genvar k = 0; k < NBYTES; k++) begin : g_byte
      if (8*k + 8 <= DATA_W) begin : g_in
         assign in_bytes[k] = bus.in_d[8*k +: 8];
      end else begin : g_pad
         assign in_bytes[k] = '0;
      end
   end
   wire unused_in = ^bus.in_d;

   // A level already high when reset releases is not an edge: arm only after seeing in_rdy low.
   assign trig = bus.in_rdy & ~prev_rdy & armed;

   always_comb begin
      state_n = state;
      load    = 1'b0;
      adv     = 1'b0;
      start_n = 1'b0;
      case (state)
         IDLE:      if (trig) begin state_n = SEND; load = 1'b1; end
         SEND:      if (!bus.tx_busy) begin state_n = WAIT_ACK; start_n = 1'b1; end
         WAIT_ACK:  if (bus.tx_busy) state_n = WAIT_DONE;
         WAIT_DONE: if (!bus.tx_busy) begin
                       if (idx == last) state_n = DONE;
                       else begin state_n = SEND; adv = 1'b1; end
                    end
         DONE:      state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_rdy   <= 1'b0;
         armed      <= 1'b0;
         cap        <= '0;
         last       <= '0;
         idx        <= '0;
         tx_d_q     <= '0;
         tx_start_q <= 1'b0;
      end else begin
         prev_rdy   <= bus.in_rdy;
         tx_start_q <= start_n;
         if (!bus.in_rdy) armed <= 1'b1;
         if (load) begin
            cap  <= in_bytes;
            last <= bus.in_bytecount;
            idx  <= '0;
         end
         if (adv)     idx    <= idx + CNT_W'(1);
         if (start_n) tx_d_q <= cap[idx];
      end
   end

   assign bus.tx_d     = tx_d_q;
   assign bus.tx_start = tx_start_q;
   assign bus.busy     = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_DONE);
   assign bus.pkt_done = (state == DONE);
endmodule

// File: tb/tb_pkt_tx_serializer.sv
// Randomized bench for pkt_tx_serializer: a UART busy model, a byte monitor and
// an expected-byte queue built from each packet's word and last index.
module tb_pkt_tx_serializer;
   localparam int DATA_W = 256;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   pkt_tx_serializer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   pkt_tx_serializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // UART tx model: busy for busy_len cycles after it samples tx_start; force_busy adds backpressure.
   int   busy_len = 5;
   int   busy_cnt;
   logic force_busy = 1'b0;
   assign bus.tx_busy = force_busy | (busy_cnt != 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             busy_cnt <= 0;
      else if (bus.tx_start)  busy_cnt <= busy_len;
      else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
   end

   // Byte monitor: records every transmitted byte and checks handshake rules.
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   logic       holding = 1'b0;
   logic       seen_b = 1'b0;
   logic [7:0] hold_d;

   always @(negedge clk) begin
      if (!rst_n) begin
         holding = 1'b0;
      end else begin
         if (bus.tx_start) begin
            got_q.push_back(bus.tx_d);
            chk("start_while_busy", bus.tx_busy, 1'b0);
            holding = 1'b1;
            seen_b  = 1'b0;
            hold_d  = bus.tx_d;
         end else if (holding) begin
            chk("tx_d_hold", bus.tx_d, hold_d);
            if (bus.tx_busy) seen_b = 1'b1;
            else if (seen_b) holding = 1'b0;
         end
         if (bus.pkt_done) done_cnt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic model_pkt(input logic [DATA_W-1:0] d, input int cnt);
      for (int k = 0; k <= cnt; k++) exp_q.push_back(d[8*k +: 8]);
   endtask

   task automatic wait_done(input int d0, input int lim);
      int n = 0;
      while (done_cnt == d0 && n < lim) begin
         cyc(1);
         n++;
      end
      chk("done_seen", done_cnt, d0 + 1);
   endtask

   task automatic check_stream(input string tag);
      int n;
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input int cnt, input int hold);
      int d0;
      model_pkt(d, cnt);
      d0 = done_cnt;
      bus.in_d         = d;
      bus.in_bytecount = CNT_W'(cnt);
      bus.in_rdy       = 1'b1;
      cyc(hold);
      wait_done(d0, 2000);
      bus.in_rdy = 1'b0;
      cyc(2);
      chk("done_once", done_cnt, d0 + 1);
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W / 32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, n;
      logic [DATA_W-1:0] d;

      bus.in_d         = '0;
      bus.in_bytecount = '0;
      bus.in_rdy       = 1'b0;
      cyc(3);
      chk("rst_tx_d",     bus.tx_d, 8'h00);
      chk("rst_tx_start", bus.tx_start, 1'b0);
      chk("rst_busy",     bus.busy, 1'b0);
      chk("rst_pkt_done", bus.pkt_done, 1'b0);
      rst_n = 1'b1;
      cyc(2);

      // single byte with in_rdy held 20 cycles: one send, latency 2
      busy_len = 5;
      model_pkt(256'hfe, 0);
      d0 = done_cnt;
      bus.in_d = 256'hfe; bus.in_bytecount = '0; bus.in_rdy = 1'b1;
      cyc(1);
      chk("lat1_start", bus.tx_start, 1'b0);
      cyc(1);
      chk("lat2_start", bus.tx_start, 1'b1);
      chk("lat2_tx_d",  bus.tx_d, 8'hfe);
      chk("lat2_busy",  bus.busy, 1'b1);
      cyc(18);
      bus.in_rdy = 1'b0;
      chk("single_done", done_cnt, d0 + 1);
      chk("single_idle", bus.busy, 1'b0);
      check_stream("single");
      cyc(2);

      send(256'h33_22_11, 2, 3);
      check_stream("multi");

      // re-trigger while busy is ignored; upstream changes after capture have no effect
      d = rand_word();
      model_pkt(d, 3);
      d0 = done_cnt;
      bus.in_d = d; bus.in_bytecount = CNT_W'(3); bus.in_rdy = 1'b1;
      cyc(2);
      bus.in_rdy = 1'b0;
      cyc(3);
      bus.in_rdy = 1'b1; bus.in_d = rand_word(); bus.in_bytecount = CNT_W'(15);
      cyc(3);
      bus.in_rdy = 1'b0;
      wait_done(d0, 2000);
      cyc(2);
      send(rand_word(), 1, 2);
      check_stream("retrig");

      // backpressure: start withheld while tx_busy, then within one cycle of release
      force_busy = 1'b1;
      d = rand_word();
      model_pkt(d, 1);
      d0 = done_cnt;
      bus.in_d = d; bus.in_bytecount = CNT_W'(1); bus.in_rdy = 1'b1;
      cyc(10);
      chk("bp_withheld", got_q.size(), 0);
      force_busy = 1'b0;
      cyc(1);
      chk("bp_start", bus.tx_start, 1'b1);
      wait_done(d0, 2000);
      bus.in_rdy = 1'b0;
      cyc(2);
      check_stream("bp");

      // full length: byte k = k, upper half random and never sent
      d = rand_word();
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
      send(d, 15, 2);
      check_stream("full");

      for (int t = 0; t < 20; t++) begin
         busy_len = $urandom_range(1, 6);
         send(rand_word(), $urandom_range(0, 15), $urandom_range(1, 5));
         check_stream("rand");
      end

      // reset during byte 2 of a 4-byte packet
      busy_len = 5;
      d = rand_word();
      bus.in_d = d; bus.in_bytecount = CNT_W'(3); bus.in_rdy = 1'b1;
      n = 0;
      while (got_q.size() < 2 && n < 200) begin
         cyc(1);
         n++;
      end
      chk("rst_reach_b2", got_q.size(), 2);
      cyc(2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_d",     bus.tx_d, 8'h00);
      chk("mid_rst_tx_start", bus.tx_start, 1'b0);
      chk("mid_rst_busy",     bus.busy, 1'b0);
      chk("mid_rst_pkt_done", bus.pkt_done, 1'b0);
      got_q.delete();
      exp_q.delete();
      cyc(2);
      rst_n = 1'b1;
      d0 = done_cnt;
      cyc(20);
      chk("post_rst_no_tx",   got_q.size(), 0);
      chk("post_rst_no_done", done_cnt, d0);
      chk("post_rst_busy",    bus.busy, 1'b0);
      bus.in_rdy = 1'b0;
      cyc(2);
      send(d, 3, 2);
      check_stream("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
